// File: rtl/coin_feeder_pkg.sv
// Shared definitions for the coin feeder: coin codes, coin values, FSM state encoding.
package coin_feeder_pkg;

  typedef enum logic [1:0] {
    CODE_NONE = 2'b00,
    CODE_100  = 2'b01,
    CODE_200  = 2'b10,
    CODE_500  = 2'b11
  } coin_code_t;

  localparam logic [3:0] VAL_100 = 4'd1;
  localparam logic [3:0] VAL_200 = 4'd2;
  localparam logic [3:0] VAL_500 = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_WAIT_RESP,
    ST_SETTLE
  } state_t;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    logic [3:0] v;
    case (code)
      CODE_100: v = VAL_100;
      CODE_200: v = VAL_200;
      CODE_500: v = VAL_500;
      default:  v = 4'd0;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hf : s[3:0];
  endfunction

endpackage

// File: rtl/coin_fifo.sv
// Synchronous coin token FIFO (DEPTH x W bits) with full/empty flags.
module coin_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/coin_feeder.sv
// Coin-side driver for the vending machine: queues coin tokens, pulses in100/in200/in500,
// tallies change and closes each purchase. Define CHANGE_AUDIT_EN to flag paid-change != PRICE.
//
// state     | meaning
// IDLE      | no coin in flight; pops the next queued token
// PULSE     | one coin line high for PULSE_CYCLES
// GAP       | all coin lines low for GAP_CYCLES
// WAIT_RESP | price reached, waiting for delivery (bounded by RESP_TIMEOUT)
// SETTLE    | delivered; change still counted for SETTLE_CYCLES
module coin_feeder
  import coin_feeder_pkg::*;
#(
  parameter int PRICE         = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int PULSE_CYCLES  = 1,
  parameter int GAP_CYCLES    = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int RESP_TIMEOUT  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_code,
  output logic       coin_ready,
  output logic       in100,
  output logic       in200,
  output logic       in500,
  input  logic       out100,
  input  logic       out200,
  input  logic       delivery,
  output logic       busy,
  output logic [3:0] paid_total,
  output logic [3:0] change_total,
  output logic       txn_done,
  output logic       txn_error
);

  localparam int TW = 8;
  localparam logic [3:0] PRICE_V = 4'(PRICE);

  state_t        state, state_nxt;
  logic [1:0]    cur_code;
  logic [TW-1:0] phase_cnt, resp_cnt;
  logic          phase_tc, resp_tc;
  logic          deliv_seen, open_txn, timeout;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]    fifo_rdata;
  logic [3:0]    paid_inc;

  // Illegal code 00 is handshaken but never stored, so it can never pulse.
  assign coin_ready = !fifo_full;
  assign fifo_push  = coin_valid && !fifo_full && (coin_code != CODE_NONE);
  assign busy       = (state != ST_IDLE) || !fifo_empty;
  assign phase_tc   = (phase_cnt == '0);
  assign resp_tc    = (resp_cnt == '0);
  assign open_txn   = (state != ST_IDLE) || (paid_total != '0);
  assign paid_inc   = sat_add(paid_total, coin_value(fifo_rdata));

  coin_fifo #(.DEPTH(FIFO_DEPTH), .W(2)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (coin_code),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // GAP falls straight into the next PULSE when a coin is waiting, keeping pulses GAP_CYCLES apart.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (deliv_seen) state_nxt = ST_SETTLE;
        else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_PULSE;
        end
      end
      ST_PULSE: if (phase_tc) state_nxt = ST_GAP;
      ST_GAP: begin
        if (phase_tc) begin
          if (deliv_seen || delivery)  state_nxt = ST_SETTLE;
          else if (paid_total >= PRICE_V) state_nxt = ST_WAIT_RESP;
          else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = ST_PULSE;
          end else state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_RESP: begin
        if (resp_tc)       state_nxt = ST_IDLE;
        else if (delivery) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: if (phase_tc) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in100    = 1'b0;
    in200    = 1'b0;
    in500    = 1'b0;
    txn_done = 1'b0;
    timeout  = 1'b0;
    if (state == ST_PULSE) begin
      case (cur_code)
        CODE_100: in100 = 1'b1;
        CODE_200: in200 = 1'b1;
        CODE_500: in500 = 1'b1;
        default:  ;
      endcase
    end
    if (state == ST_WAIT_RESP && resp_tc) begin
      txn_done = 1'b1;
      timeout  = 1'b1;
    end
    if (state == ST_SETTLE && phase_tc) txn_done = 1'b1;
  end

`ifdef CHANGE_AUDIT_EN
  logic [4:0] net_paid;
  assign net_paid  = {1'b0, paid_total} - {1'b0, change_total};
  assign txn_error = txn_done && (timeout || (net_paid != 5'(PRICE)));
`else
  assign txn_error = txn_done && timeout;
`endif

  // The response timer starts when a pulse lifts paid_total to the price, not on WAIT_RESP entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_cnt    <= '0;
      resp_cnt     <= '0;
      cur_code     <= CODE_NONE;
      paid_total   <= '0;
      change_total <= '0;
      deliv_seen   <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        case (state_nxt)
          ST_PULSE:  phase_cnt <= TW'(PULSE_CYCLES - 1);
          ST_GAP:    phase_cnt <= TW'(GAP_CYCLES - 1);
          ST_SETTLE: phase_cnt <= TW'(SETTLE_CYCLES - 1);
          default:   phase_cnt <= '0;
        endcase
      end else if (!phase_tc) phase_cnt <= phase_cnt - 1'b1;

      if (fifo_pop && paid_total < PRICE_V && paid_inc >= PRICE_V) resp_cnt <= TW'(RESP_TIMEOUT);
      else if (!resp_tc) resp_cnt <= resp_cnt - 1'b1;

      if (fifo_pop) cur_code <= fifo_rdata;

      if (txn_done) begin
        paid_total   <= '0;
        change_total <= '0;
        deliv_seen   <= 1'b0;
      end else begin
        if (fifo_pop) paid_total <= paid_inc;
        if (open_txn) change_total <= sat_add(change_total, {2'b00, out200, out100});
        if (state_nxt == ST_SETTLE) deliv_seen <= 1'b0;
        else if (delivery && open_txn && state != ST_WAIT_RESP && state != ST_SETTLE)
          deliv_seen <= 1'b1;
      end
    end
  end

endmodule
